// File: rtl/sdram_wr_buf.sv
// sdram_wr_buf: buffers the windowed RGB565 pixel stream in a FWFT FIFO and
// hands it to the SDRAM controller as fixed-length write bursts with linear
// frame addresses that wrap at frame end.
module sdram_wr_buf #(
  parameter int unsigned           BURST_LEN   = 256,
  parameter int unsigned           FIFO_DEPTH  = 1024,
  parameter int unsigned           ADDR_W      = 24,
  parameter logic [ADDR_W-1:0]     BASE_ADDR   = '0,
  parameter int unsigned           FRAME_WORDS = 307200
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          pix_en,
  input  logic [15:0]                   pix_data,
  input  logic                          frame_start,
  output logic                          wr_req,
  output logic [ADDR_W-1:0]             wr_addr,
  input  logic                          wr_ack,
  input  logic                          wr_data_req,
  output logic [15:0]                   wr_data,
  input  logic                          wr_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic                          sync_err,
  output logic                          frame_done
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W  = PTR_W + 1;
  localparam int unsigned BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [ADDR_W-1:0] END_ADDR = BASE_ADDR + ADDR_W'(FRAME_WORDS);

  typedef enum logic [1:0] {IDLE, REQ, DATA, DONE} state_t;

  state_t              state_q, state_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, wr_idx_c;
  logic [LVL_W-1:0]    count_q, count_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [ADDR_W-1:0]   addr_q, addr_d, next_addr_c;
  logic                wr_req_q, wr_req_d;
  logic                done_seen_q, done_seen_d;
  logic                pending_q, pending_d;
  logic                overflow_q, overflow_d;
  logic                sync_err_q, sync_err_d;
  logic                frame_done_q, frame_done_d;
  logic                full_c, empty_c, push_c, pop_c;
  logic                clr_idle_c, clr_pend_c, clear_c, done_now_c, pend_now_c;

  logic [15:0] mem [FIFO_DEPTH];

  // FIFO push/pop/clear decisions
  always_comb begin
    full_c      = (count_q == LVL_W'(FIFO_DEPTH));
    empty_c     = (count_q == '0);
    done_now_c  = (state_q == DONE) && (wr_done || done_seen_q);
    pend_now_c  = pending_q || (frame_start && (state_q != IDLE));
    clr_idle_c  = (state_q == IDLE) && frame_start;
    clr_pend_c  = done_now_c && pend_now_c;
    clear_c     = clr_idle_c || clr_pend_c;
    pop_c       = (state_q == DATA) && wr_data_req && !empty_c;
    // a pixel coincident with frame_start in IDLE becomes word 0 of the new frame
    push_c      = pix_en && (clr_idle_c || (!clr_pend_c && (!full_c || pop_c)));
    wr_idx_c    = clear_c ? '0 : wr_ptr_q;
    wr_ptr_d    = wr_idx_c + PTR_W'(push_c);
    rd_ptr_d    = clear_c ? '0 : rd_ptr_q + PTR_W'(pop_c);
    count_d     = clear_c ? LVL_W'(push_c)
                          : count_q + LVL_W'(push_c) - LVL_W'(pop_c);
    overflow_d  = overflow_q || (pix_en && !clear_c && full_c && !pop_c);
    sync_err_d  = sync_err_q || (frame_start && (state_q != IDLE));
    next_addr_c = addr_q + ADDR_W'(BURST_LEN);
  end

  // Burst FSM next state, address and pulse outputs
  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    addr_d       = addr_q;
    done_seen_d  = done_seen_q;
    pending_d    = pend_now_c;
    frame_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (clr_idle_c) begin
          addr_d = BASE_ADDR;
        end else if (count_q >= LVL_W'(BURST_LEN)) begin
          state_d = REQ;
        end
      end
      REQ: begin
        if (wr_ack) begin
          state_d     = DATA;
          beat_d      = '0;
          done_seen_d = 1'b0;
        end
      end
      DATA: begin
        if (wr_done) done_seen_d = 1'b1;
        if (pop_c) begin
          beat_d = beat_q + BEAT_W'(1);
          if (beat_q == BEAT_W'(BURST_LEN - 1)) state_d = DONE;
        end
      end
      DONE: begin
        if (done_now_c) begin
          state_d     = IDLE;
          done_seen_d = 1'b0;
          if (pend_now_c) begin
            addr_d    = BASE_ADDR;
            pending_d = 1'b0;
          end else if (next_addr_c == END_ADDR) begin
            addr_d       = BASE_ADDR;
            frame_done_d = 1'b1;
          end else begin
            addr_d = next_addr_c;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    wr_req_d = (state_d == REQ);
  end

  // State and control registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      beat_q       <= '0;
      addr_q       <= BASE_ADDR;
      wr_req_q     <= 1'b0;
      done_seen_q  <= 1'b0;
      pending_q    <= 1'b0;
      overflow_q   <= 1'b0;
      sync_err_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      beat_q       <= beat_d;
      addr_q       <= addr_d;
      wr_req_q     <= wr_req_d;
      done_seen_q  <= done_seen_d;
      pending_q    <= pending_d;
      overflow_q   <= overflow_d;
      sync_err_q   <= sync_err_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Pixel storage; contents need no reset since pointers define validity
  always_ff @(posedge clk) begin
    if (push_c) mem[wr_idx_c] <= pix_data;
  end

  assign wr_data    = mem[rd_ptr_q];
  assign wr_req     = wr_req_q;
  assign wr_addr    = addr_q;
  assign fifo_level = count_q;
  assign overflow   = overflow_q;
  assign sync_err   = sync_err_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_sdram_wr_buf.sv
// Directed bench for sdram_wr_buf: burst packing, frame wrap, overflow,
// concurrent push/pop, frame resync and mid-burst reset.
module tb_sdram_wr_buf;

  localparam int unsigned BL = 256;
  localparam int unsigned FD = 1024;
  localparam int unsigned FW = 2048;

  logic        clk = 1'b0;
  logic        rst, pix_en, frame_start, wr_ack, wr_data_req, wr_done;
  logic [15:0] pix_data, wr_data;
  logic        wr_req, overflow, sync_err, frame_done;
  logic [23:0] wr_addr;
  logic [10:0] fifo_level;

  int n_tests = 0;
  int n_fail  = 0;

  sdram_wr_buf #(.BURST_LEN(BL), .FIFO_DEPTH(FD), .ADDR_W(24),
                 .BASE_ADDR(24'd0), .FRAME_WORDS(FW)) dut (
    .clk(clk), .rst(rst), .pix_en(pix_en), .pix_data(pix_data),
    .frame_start(frame_start), .wr_req(wr_req), .wr_addr(wr_addr),
    .wr_ack(wr_ack), .wr_data_req(wr_data_req), .wr_data(wr_data),
    .wr_done(wr_done), .fifo_level(fifo_level), .overflow(overflow),
    .sync_err(sync_err), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic push_n(input int n, input logic [15:0] base);
    for (int i = 0; i < n; i++) begin
      pix_en   = 1'b1;
      pix_data = base + 16'(i);
      tick();
    end
    pix_en = 1'b0;
  endtask

  // pops n words, counting head words that differ from base, base+1, ...
  task automatic pop_n(input int n, input logic [15:0] base, output int bad);
    bad = 0;
    for (int i = 0; i < n; i++) begin
      wr_data_req = 1'b1;
      if (wr_data !== base + 16'(i)) bad++;
      tick();
    end
    wr_data_req = 1'b0;
  endtask

  task automatic wait_req(input string tag);
    for (int i = 0; i < 20 && !wr_req; i++) tick();
    chk(tag, 32'(wr_req), 32'd1);
  endtask

  task automatic ack();
    wr_ack = 1'b1;
    tick();
    wr_ack = 1'b0;
  endtask

  task automatic done_pulse();
    wr_done = 1'b1;
    tick();
    wr_done = 1'b0;
  endtask

  initial begin
    int bad, addr_bad, fd_cnt;
    rst = 1'b0; pix_en = 1'b0; pix_data = '0; frame_start = 1'b0;
    wr_ack = 1'b0; wr_data_req = 1'b0; wr_done = 1'b0;

    // reset state and a single burst
    do_reset();
    chk("rst_wr_req",     32'(wr_req),     32'd0);
    chk("rst_wr_addr",    32'(wr_addr),    32'd0);
    chk("rst_level",      32'(fifo_level), 32'd0);
    chk("rst_overflow",   32'(overflow),   32'd0);
    chk("rst_sync_err",   32'(sync_err),   32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    push_n(256, 16'h0000);
    chk("t1_level_256",   32'(fifo_level), 32'd256);
    chk("t1_req_not_yet", 32'(wr_req),     32'd0);
    tick();
    chk("t1_req_rise",    32'(wr_req),     32'd1);
    chk("t1_req_addr",    32'(wr_addr),    32'd0);
    ack();
    chk("t1_req_drop",    32'(wr_req),     32'd0);
    pop_n(256, 16'h0000, bad);
    chk("t1_data_order",  32'(bad),        32'd0);
    done_pulse();
    chk("t1_level_end",   32'(fifo_level), 32'd0);
    chk("t1_addr_end",    32'(wr_addr),    32'd256);

    // full (reduced) frame: 8 bursts then wrap
    do_reset();
    addr_bad = 0; fd_cnt = 0;
    for (int b = 0; b < 8; b++) begin
      push_n(256, 16'(b * 256));
      wait_req("t2_req");
      if (wr_addr !== 24'(b * 256)) addr_bad++;
      ack();
      pop_n(256, 16'(b * 256), bad);
      addr_bad += bad;
      done_pulse();
      fd_cnt += int'(frame_done);
    end
    chk("t2_addr_seq_data", 32'(addr_bad), 32'd0);
    chk("t2_wrap_addr",     32'(wr_addr),  32'd0);
    tick();
    fd_cnt += int'(frame_done);
    chk("t2_frame_done_cnt", 32'(fd_cnt),   32'd1);
    chk("t2_frame_done_low", 32'(frame_done), 32'd0);

    // overflow with a stalled controller, then drain
    do_reset();
    push_n(1100, 16'h0000);
    chk("t3_level_sat", 32'(fifo_level), 32'd1024);
    chk("t3_overflow",  32'(overflow),   32'd1);
    chk("t3_req_held",  32'(wr_req),     32'd1);
    addr_bad = 0;
    for (int b = 0; b < 4; b++) begin
      wait_req("t3_req");
      ack();
      pop_n(256, 16'(b * 256), bad);
      addr_bad += bad;
      done_pulse();
    end
    chk("t3_drain_data",   32'(addr_bad),   32'd0);
    chk("t3_drain_level",  32'(fifo_level), 32'd0);
    chk("t3_overflow_sticky", 32'(overflow), 32'd1);
    do_reset();
    chk("t3_overflow_rst", 32'(overflow),   32'd0);

    // concurrent push and pop at level 600
    push_n(600, 16'h0000);
    wait_req("t4_req");
    ack();
    chk("t4_level_600", 32'(fifo_level), 32'd600);
    bad = 0; addr_bad = 0;
    for (int i = 0; i < 256; i++) begin
      wr_data_req = 1'b1;
      pix_en      = 1'b1;
      pix_data    = 16'(600 + i);
      if (wr_data !== 16'(i)) bad++;
      tick();
      if (fifo_level !== 11'd600) addr_bad++;
    end
    wr_data_req = 1'b0; pix_en = 1'b0;
    chk("t4_order",       32'(bad),      32'd0);
    chk("t4_level_const", 32'(addr_bad), 32'd0);
    done_pulse();
    wait_req("t4_req2");
    chk("t4_addr2", 32'(wr_addr), 32'd256);
    ack();
    pop_n(256, 16'd256, bad);
    chk("t4_order2", 32'(bad), 32'd0);
    done_pulse();

    // frame_start during DATA after 100 beats
    do_reset();
    push_n(300, 16'h0000);
    wait_req("t5_req");
    ack();
    pop_n(100, 16'h0000, bad);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("t5_sync_err", 32'(sync_err), 32'd1);
    pop_n(156, 16'd100, addr_bad);
    chk("t5_burst_completes", 32'(bad + addr_bad), 32'd0);
    push_n(20, 16'h7000);
    done_pulse();
    chk("t5_level_clear", 32'(fifo_level), 32'd0);
    chk("t5_addr_base",   32'(wr_addr),    32'd0);
    chk("t5_no_frame_done", 32'(frame_done), 32'd0);
    push_n(256, 16'hA000);
    wait_req("t5_req2");
    chk("t5_addr_new", 32'(wr_addr), 32'd0);
    ack();
    pop_n(256, 16'hA000, bad);
    chk("t5_new_data", 32'(bad), 32'd0);
    done_pulse();
    chk("t5_sync_sticky", 32'(sync_err), 32'd1);

    // reset mid-burst, stray wr_done ignored
    do_reset();
    push_n(256, 16'h0000);
    wait_req("t6_req");
    ack();
    pop_n(50, 16'h0000, bad);
    do_reset();
    chk("t6_wr_req", 32'(wr_req),     32'd0);
    chk("t6_level",  32'(fifo_level), 32'd0);
    chk("t6_addr",   32'(wr_addr),    32'd0);
    done_pulse();
    chk("t6_stray_done_addr", 32'(wr_addr), 32'd0);
    chk("t6_stray_done_req",  32'(wr_req),  32'd0);

    // early wr_done latched during DATA
    push_n(256, 16'h1000);
    wait_req("t7_req");
    ack();
    pop_n(200, 16'h1000, bad);
    wr_done = 1'b1;
    tick();
    wr_done = 1'b0;
    pop_n(56, 16'h10C8, addr_bad);
    chk("t7_data", 32'(bad + addr_bad), 32'd0);
    tick();
    chk("t7_early_done_addr", 32'(wr_addr), 32'd256);

    // frame_start in IDLE keeps the coincident pixel
    push_n(10, 16'h2000);
    frame_start = 1'b1; pix_en = 1'b1; pix_data = 16'hBEEF;
    tick();
    frame_start = 1'b0; pix_en = 1'b0;
    chk("t8_level_1", 32'(fifo_level), 32'd1);
    chk("t8_addr_0",  32'(wr_addr),    32'd0);
    push_n(255, 16'h3000);
    wait_req("t8_req");
    ack();
    chk("t8_first_word", 32'(wr_data), 32'h0000BEEF);
    wr_data_req = 1'b1;
    tick();
    wr_data_req = 1'b0;
    pop_n(255, 16'h3000, bad);
    chk("t8_rest", 32'(bad), 32'd0);
    done_pulse();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sdram_wr_buf.md
Name: sdram_wr_buf

Overview:
- Downstream of the window cropper: accepts the windowed RGB565 pixel stream (enable + 16-bit data) and packs it into fixed-length SDRAM write bursts.
- Buffers pixels in an internal FIFO, issues burst requests with linear frame addresses to the SDRAM controller, and wraps the address at frame end.
- Flags FIFO overflow and frame-resync events.

Parameters:
- BURST_LEN, 256, words per SDRAM write burst (power of 2, ≤ FIFO_DEPTH/2)
- FIFO_DEPTH, 1024, pixel FIFO depth in 16-bit words (power of 2)
- ADDR_W, 24, SDRAM word-address width
- BASE_ADDR, 24'd0, frame buffer start word address
- FRAME_WORDS, 307200, words per frame (640x480); must be a multiple of BURST_LEN

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- pix_en  in  1  pixel valid from window stage
- pix_data  in  16  RGB565 pixel
- frame_start  in  1  one-cycle pulse marking the start of a new frame (before its first pixel or coincident with it)
- wr_req  out  1  burst request to SDRAM controller
- wr_addr  out  ADDR_W  burst start word address; stable while wr_req=1
- wr_ack  in  1  one-cycle pulse: controller accepted request
- wr_data_req  in  1  controller pops one word this cycle
- wr_data  out  16  FIFO head word (first-word-fall-through)
- wr_done  in  1  one-cycle pulse: burst fully written
- fifo_level  out  log2(FIFO_DEPTH)+1  current word count
- overflow  out  1  sticky: pixel dropped on full FIFO
- sync_err  out  1  sticky: frame_start arrived while a burst was active
- frame_done  out  1  one-cycle pulse when the last burst of a frame completes

Behaviour:
- Reset values: wr_req=0, wr_addr=BASE_ADDR, fifo_level=0, overflow=0, sync_err=0, frame_done=0. The FIFO is emptied and the FSM goes to IDLE. Reset mid-burst abandons the burst immediately; no wr_done is awaited.
- FIFO write:
  - pix_en=1 and not full: word is stored; fifo_level increments on the next edge.
  - pix_en=1 and full: pixel is dropped and overflow is set. overflow clears only on rst.
  - Push and pop in the same cycle: level unchanged; both take effect.
  - Full and pop in the same cycle as pix_en: the push is accepted.
- wr_data always shows the FIFO head combinationally. It is undefined when the FIFO is empty.
- FSM states: IDLE, REQ, DATA, DONE.
  - IDLE -> REQ: when fifo_level ≥ BURST_LEN at a clock edge. wr_req is registered and rises 1 cycle later.
  - REQ: hold wr_req=1 and wr_addr. On wr_ack, wr_req drops on the next edge and the FSM goes to DATA.
  - DATA: each wr_data_req=1 pops one word. A beat counter counts to BURST_LEN, then the FSM goes to DONE. wr_data_req outside DATA is ignored (no pop). Further wr_data_req after BURST_LEN pops is ignored.
  - DONE: wait for wr_done, then advance the address.
    - wr_addr += BURST_LEN.
    - If the new value equals BASE_ADDR+FRAME_WORDS: wr_addr=BASE_ADDR and pulse frame_done for 1 cycle.
    - Return to IDLE.
  - wr_done arriving while still in DATA (early) is latched and honoured at DONE entry.
- frame_start:
  - In IDLE: the FIFO is cleared and wr_addr=BASE_ADDR on the next edge. A pixel coincident with frame_start is kept as the first word of the new frame.
  - In REQ, DATA or DONE:
    - A pending flag is set and sync_err is set (sticky until rst).
    - The current burst completes normally.
    - On return to IDLE, the FIFO is cleared and wr_addr=BASE_ADDR. Pixels accepted while pending are discarded.
    - frame_done is not pulsed for the abandoned frame.
- Partial tail (< BURST_LEN words) is never written. FRAME_WORDS being a multiple of BURST_LEN guarantees no tail in normal operation.
- No combinational path from inputs to wr_req. fifo_level and the FSM outputs are registered.

Test Plan:
- Reset, then 256 consecutive pix_en with data 0x0000..0x00FF -> wr_req rises 1 cycle after level reaches 256, with wr_addr=0. After wr_ack, 256 wr_data_req cycles read 0x0000..0x00FF in order. After wr_done, fifo_level=0 and wr_addr=256.
- Stream a full 640x480 frame with the controller acking each burst immediately -> 1200 bursts, with wr_addr sequence 0,256,...,306944. frame_done pulses once after the 1200th wr_done, and wr_addr returns to 0.
- Controller stalls (never acks) while 1100 pixels are pushed -> fifo_level saturates at 1024, 76 pixels dropped, overflow=1. overflow stays 1 after later bursts drain the FIFO until rst.
- Push and pop in the same cycle at level 600 during DATA -> fifo_level stays 600 and wr_data order is preserved.
- frame_start pulsed in DATA after 100 beats -> the burst finishes 256 beats and sync_err=1. On return to IDLE, fifo_level=0 and wr_addr=0. The next 256 pixels form a burst at address 0.
- rst asserted in DATA mid-burst -> next cycle wr_req=0, fifo_level=0, wr_addr=BASE_ADDR, FSM in IDLE. A subsequent wr_done is ignored.
